// File: rtl/ctr8_arb.sv
// Round-robin scheduler sharing one external 8-bit loadable up-counter among NREQ timeout requesters.
// Optional build macro CTR8_ARB_PERIODIC_EN adds the per input for back-to-back periodic reloads.
module ctr8_arb #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] len,
`ifdef CTR8_ARB_PERIODIC_EN
  input  logic [NREQ-1:0]   per,
`endif
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic              ctr_rst_n,
  output logic              ctr_ld,
  output logic [7:0]        ctr_d,
  input  logic              ctr_co
);

  localparam int PTR_W = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  sel_q, sel_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;

  logic              req_sel;
  logic [7:0]        len_sel;
  logic [PTR_W-1:0]  pick;

  // First requester at or after p, wrapping modulo NREQ; scanning far-to-near lets the nearest win.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] best;
    int               ix;
    best = p;
    for (int k = NREQ - 1; k >= 0; k--) begin
      ix = (int'(p) + k) % NREQ;
      if (r[ix]) best = PTR_W'(ix);
    end
    return best;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] s);
    return (s == PTR_W'(NREQ - 1)) ? '0 : s + PTR_W'(1);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] s);
    return NREQ'(1) << s;
  endfunction

  assign req_sel = req[sel_q];
  assign len_sel = len[{sel_q, 3'b000} +: 8];
  assign pick    = rr_pick(req, ptr_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          sel_d   = pick;
          gnt_d   = onehot(pick);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!req_sel) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = next_ptr(sel_q);
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        // A dropped request beats a coincident carry: no done for an abandoned timeout.
        if (!req_sel) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = next_ptr(sel_q);
        end else if (ctr_co) begin
          state_d = DONE;
          done_d  = gnt_q;
        end
      end
      DONE: begin
`ifdef CTR8_ARB_PERIODIC_EN
        if (per[sel_q] && req_sel) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = next_ptr(sel_q);
        end
`else
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = next_ptr(sel_q);
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  // Counter drive is a pure decode of state, so reset holds the counter cleared via IDLE.
  assign gnt       = gnt_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign ctr_rst_n = (state_q != IDLE);
  assign ctr_ld    = (state_q == LOAD);
  assign ctr_d     = (state_q == LOAD) ? (8'd0 - len_sel) : 8'd0;

endmodule

// File: tb/tb_ctr8_arb.sv
// Scoreboard bench for ctr8_arb with a behavioural model of the shared 8-bit counter.
module tb_ctr8_arb;
  localparam int NREQ  = 4;
  localparam int CLK_P = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] len;
`ifdef CTR8_ARB_PERIODIC_EN
  logic [NREQ-1:0]   per;
`endif
  logic [NREQ-1:0]   gnt, done;
  logic              busy, ctr_rst_n, ctr_ld, ctr_co;
  logic [7:0]        ctr_d, cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic [NREQ-1:0] mask;
    int              at;
  } exp_t;
  exp_t sb[$];

  ctr8_arb #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .len       (len),
`ifdef CTR8_ARB_PERIODIC_EN
    .per       (per),
`endif
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .ctr_rst_n (ctr_rst_n),
    .ctr_ld    (ctr_ld),
    .ctr_d     (ctr_d),
    .ctr_co    (ctr_co)
  );

  always #(CLK_P/2) clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared counter: co is a registered terminal-count flag, high in the cycle the count reads FF.
  always @(posedge clk) begin
    if (!ctr_rst_n) begin
      cnt    <= 8'd0;
      ctr_co <= 1'b0;
    end else if (ctr_ld) begin
      cnt    <= ctr_d;
      ctr_co <= (ctr_d == 8'hFF);
    end else begin
      cnt    <= cnt + 8'd1;
      ctr_co <= (cnt == 8'hFE);
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_len(input int i, input int v);
    len[8*i +: 8] = v[7:0];
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst === 1'b0) begin
      chk("gnt_multi", ($countones(gnt) > 1) ? 32'd1 : 32'd0, 32'd0);
      chk("done_outside_gnt", done & ~gnt, 0);
      chk("busy_vs_gnt", busy ^ (|gnt), 0);
      if (done != '0) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", done, 0);
        end else begin
          e = sb.pop_front();
          chk("done_mask", done, e.mask);
          chk("done_cycle", cyc, e.at);
        end
      end
    end
  end

  // Called at the LOAD cycle; returns at the DONE cycle after dropping dropm from req.
  task automatic grant_cycle(input logic [NREQ-1:0] mask, input int n, input logic [7:0] exp_d,
                             input logic [NREQ-1:0] dropm, input string tag);
    logic [8*NREQ-1:0] saved;
    chk({tag, "_gnt_load"}, gnt, mask);
    chk({tag, "_ld"}, ctr_ld, 1);
    chk({tag, "_d"}, ctr_d, exp_d);
    chk({tag, "_rstn"}, ctr_rst_n, 1);
    chk({tag, "_busy"}, busy, 1);
    sb.push_back('{mask: mask, at: cyc + n + 1});
    tick();
    chk({tag, "_run_ld"}, ctr_ld, 0);
    chk({tag, "_run_d"}, ctr_d, 0);
    saved = len;
    len   = ~len;
    repeat (n) tick();
    chk({tag, "_gnt_done"}, gnt, mask);
    len = saved;
    req = req & ~dropm;
  endtask

  task automatic idle_check(input string tag);
    tick();
    chk({tag, "_idle_gnt"}, gnt, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_rstn"}, ctr_rst_n, 0);
    chk({tag, "_idle_ld"}, ctr_ld, 0);
  endtask

  initial begin
    #(CLK_P * 5000);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    req = '0;
    len = '0;
`ifdef CTR8_ARB_PERIODIC_EN
    per = '0;
`endif
    #1 rst = 1'b1;
    req = '1;
    set_len(0, 7);
    tick();
    tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rstn", ctr_rst_n, 0);
    chk("rst_ld", ctr_ld, 0);
    chk("rst_d", ctr_d, 0);
    req = '0;
    rst = 1'b0;
    tick();

    // Single request, len 5
    req = 4'b0001;
    set_len(0, 5);
    tick();
    grant_cycle(4'b0001, 5, 8'hFB, 4'b0001, "single");
    idle_check("single");

    // Pointer now at 1: requester 1 beats requester 0
    req = 4'b0011;
    set_len(1, 2);
    tick();
    grant_cycle(4'b0010, 2, 8'hFE, 4'b0011, "ptr1");
    idle_check("ptr1");

    // Boundary lengths
    req = 4'b0001;
    set_len(0, 256);
    tick();
    grant_cycle(4'b0001, 256, 8'h00, 4'b0001, "len256");
    idle_check("len256");
    req = 4'b0001;
    set_len(0, 1);
    tick();
    grant_cycle(4'b0001, 1, 8'hFF, 4'b0001, "len1");
    idle_check("len1");

    // Reset pulse in IDLE returns the pointer to 0, then full round robin
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_len(i, 3);
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      grant_cycle(4'(1 << (k % 4)), 3, 8'hFD, (k == 4) ? 4'b1111 : 4'b0000, "rr");
      idle_check("rr");
      if (k < 4) tick();
    end

    // Abort in RUN on requester 2; requester 3 is next even with 0 pending
    set_len(2, 10);
    req = 4'b0100;
    tick();
    chk("abort_gnt_load", gnt, 4'b0100);
    chk("abort_d", ctr_d, 8'hF6);
    tick();
    tick();
    req = 4'b1001;
    tick();
    chk("abort_gnt", gnt, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rstn", ctr_rst_n, 0);
    tick();
    grant_cycle(4'b1000, 3, 8'hFD, 4'b1111, "after_abort");
    idle_check("after_abort");

    // Request dropped in the very cycle co is high
    set_len(1, 4);
    req = 4'b0010;
    tick();
    chk("race_gnt_load", gnt, 4'b0010);
    repeat (4) tick();
    chk("race_co", ctr_co, 1);
    req = 4'b0000;
    tick();
    chk("race_gnt", gnt, 0);
    chk("race_done", done, 0);

    // Asynchronous reset in the middle of RUN
    set_len(0, 20);
    req = 4'b0001;
    tick();
    chk("mrst_gnt_load", gnt, 4'b0001);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("mrst_gnt", gnt, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_rstn", ctr_rst_n, 0);
    chk("mrst_done", done, 0);
    chk("mrst_ld", ctr_ld, 0);
    tick();
    tick();
    chk("mrst_hold_rstn", ctr_rst_n, 0);
    req = '0;
    rst = 1'b0;
    tick();

    // Two requesters, requester 0 optionally periodic
    set_len(0, 4);
    set_len(1, 4);
    req = 4'b0011;
`ifdef CTR8_ARB_PERIODIC_EN
    per = 4'b0001;
    tick();
    for (int k = 0; k < 3; k++) begin
      grant_cycle(4'b0001, 4, 8'hFC, 4'b0000, "per");
      tick();
    end
    chk("per_reload_gnt", gnt, 4'b0001);
    chk("per_reload_ld", ctr_ld, 1);
    tick();
    tick();
    req = 4'b0010;
    tick();
    chk("per_abort_gnt", gnt, 0);
    tick();
    grant_cycle(4'b0010, 4, 8'hFC, 4'b0011, "per_r1");
    idle_check("per_r1");
`else
    tick();
    grant_cycle(4'b0001, 4, 8'hFC, 4'b0000, "alt0");
    idle_check("alt0");
    tick();
    grant_cycle(4'b0010, 4, 8'hFC, 4'b0000, "alt1");
    idle_check("alt1");
    tick();
    grant_cycle(4'b0001, 4, 8'hFC, 4'b0011, "alt2");
    idle_check("alt2");
`endif

    repeat (3) tick();
    chk("sb_left", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
